// File: rtl/ec_pkg.sv
// rtl/ec_pkg.sv - shared erasure-coding engine widths and packet/stripe types
package ec_pkg;

    localparam int W             = 8;
    localparam int PACKET_LENGTH = 32;

    typedef logic [PACKET_LENGTH-1:0] packet_t;
    typedef packet_t [0:W-1]          stripe_t;

endpackage

// File: rtl/parity_accumulator_if.sv
// rtl/parity_accumulator_if.sv - valid/ready stripe channel between EC pipeline stages
interface parity_accumulator_if #(
    parameter int W             = ec_pkg::W,
    parameter int PACKET_LENGTH = ec_pkg::PACKET_LENGTH
);

    logic                              valid;
    logic                              ready;
    logic [0:W-1][PACKET_LENGTH-1:0]   packets;

    modport master (output valid, output packets, input ready);
    modport slave  (input valid, input packets, output ready);

endinterface

// File: rtl/parity_accumulator.sv
// rtl/parity_accumulator.sv - XOR-accumulates K product beats into one double-buffered parity stripe
module parity_accumulator #(
    parameter int W             = ec_pkg::W,
    parameter int PACKET_LENGTH = ec_pkg::PACKET_LENGTH,
    parameter int K             = 4,
    parameter int CNT_W         = $clog2(K) + 1,
    parameter int STRIPE_CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    parity_accumulator_if.slave      product,
    parity_accumulator_if.master     parity,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [STRIPE_CNT_W-1:0]  stripe_cnt
);

    typedef logic [0:W-1][PACKET_LENGTH-1:0] stripe_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(K - 1);

    if (K < 1) begin : g_bad_k
        $error("parity_accumulator: K must be at least 1");
    end

    stripe_t acc;
    stripe_t out_packets;
    stripe_t merged;
    logic    out_valid;
    logic    last_beat;
    logic    in_fire;
    logic    out_fire;

    assign last_beat = (beat_cnt == LAST_BEAT);

    // Only the completing beat can stall, and only while the output register is still occupied.
    assign product.ready = ~clear & (~last_beat | ~out_valid | parity.ready);
    assign in_fire       = product.valid & product.ready;
    assign out_fire      = out_valid & parity.ready;

    // The first beat of a stripe overwrites, so stale accumulator contents never leak in.
    assign merged = (beat_cnt == '0) ? product.packets : (acc ^ product.packets);

    assign parity.valid   = out_valid;
    assign parity.packets = out_packets;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (in_fire) begin
            if (last_beat) begin
                beat_cnt <= '0;
            end else begin
                acc      <= merged;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_packets <= '0;
            stripe_cnt  <= '0;
        end else if (in_fire && last_beat) begin
            out_valid   <= 1'b1;
            out_packets <= merged;
            stripe_cnt  <= stripe_cnt + STRIPE_CNT_W'(1);
        end else if (out_fire) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_accumulator.sv
// tb/tb_parity_accumulator.sv - directed self-checking bench for parity_accumulator (K=4 and K=1)
module tb_parity_accumulator;
    import ec_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic clear1 = 1'b0;

    always #5 clk = ~clk;

    parity_accumulator_if a_in ();
    parity_accumulator_if a_out ();
    parity_accumulator_if b_in ();
    parity_accumulator_if b_out ();

    logic [2:0]  beat_cnt;
    logic [15:0] stripe_cnt;
    logic [0:0]  beat_cnt1;
    logic [15:0] stripe_cnt1;

    parity_accumulator #(.K(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .product    (a_in),
        .parity     (a_out),
        .beat_cnt   (beat_cnt),
        .stripe_cnt (stripe_cnt)
    );

    parity_accumulator #(.K(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear1),
        .product    (b_in),
        .parity     (b_out),
        .beat_cnt   (beat_cnt1),
        .stripe_cnt (stripe_cnt1)
    );

    int tests = 0;
    int fails = 0;
    int fire_cnt = 0;

    always @(posedge clk) begin
        if (rst_n && a_out.valid && a_out.ready) fire_cnt <= fire_cnt + 1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic stripe_t fill(input logic [31:0] v);
        stripe_t s;
        for (int i = 0; i < W; i++) s[i] = v;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input stripe_t d);
        int n;
        n = 0;
        a_in.valid   = 1'b1;
        a_in.packets = d;
        #1;
        while (!a_in.ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
        tick();
        a_in.valid = 1'b0;
    endtask

    stripe_t beats [12];
    stripe_t exp3 [3];
    int      errs;

    initial begin
        a_in.valid    = 1'b1;
        a_in.packets  = fill(32'hFFFF_FFFF);
        a_out.ready   = 1'b1;
        b_in.valid    = 1'b0;
        b_in.packets  = '0;
        b_out.ready   = 1'b1;

        // reset with in_valid held high
        tick();
        tick();
        chk("rst_out_valid", a_out.valid, 1'b0);
        chk("rst_out_packets", a_out.packets, '0);
        chk("rst_beat_cnt", beat_cnt, 3'd0);
        chk("rst_stripe_cnt", stripe_cnt, 16'd0);
        a_in.valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", a_in.ready, 1'b1);
        tick();
        tick();
        chk("idle_out_valid", a_out.valid, 1'b0);
        chk("idle_stripe_cnt", stripe_cnt, 16'd0);

        // basic stripe
        push(fill(32'h1));
        push(fill(32'h2));
        push(fill(32'h4));
        chk("basic_beat_cnt", beat_cnt, 3'd3);
        chk("basic_not_yet", a_out.valid, 1'b0);
        push(fill(32'h8));
        chk("basic_out_valid", a_out.valid, 1'b1);
        chk("basic_packets", a_out.packets, fill(32'hF));
        chk("basic_stripe_cnt", stripe_cnt, 16'd1);
        chk("basic_beat_wrap", beat_cnt, 3'd0);
        tick();
        chk("basic_drained", a_out.valid, 1'b0);

        // backpressure: stripe B's last beat waits for stripe A to leave
        a_out.ready = 1'b0;
        push(fill(32'hFFFF_FFFF));
        push(fill(32'h0));
        push(fill(32'h0));
        push(fill(32'h0));
        chk("bp_a_valid", a_out.valid, 1'b1);
        chk("bp_a_packets", a_out.packets, fill(32'hFFFF_FFFF));
        push(fill(32'h0F0F_0F0F));
        push(fill(32'h0));
        push(fill(32'h0));
        a_in.valid   = 1'b1;
        a_in.packets = fill(32'h0);
        #1;
        chk("bp_stall_ready", a_in.ready, 1'b0);
        tick();
        tick();
        tick();
        chk("bp_still_stalled", a_in.ready, 1'b0);
        chk("bp_a_held", a_out.packets, fill(32'hFFFF_FFFF));
        chk("bp_beat_cnt", beat_cnt, 3'd3);
        a_out.ready = 1'b1;
        #1;
        chk("bp_ready_comb", a_in.ready, 1'b1);
        tick();
        a_in.valid  = 1'b0;
        a_out.ready = 1'b0;
        chk("bp_b_valid", a_out.valid, 1'b1);
        chk("bp_b_packets", a_out.packets, fill(32'h0F0F_0F0F));
        chk("bp_stripe_cnt", stripe_cnt, 16'd3);
        a_out.ready = 1'b1;
        tick();
        chk("bp_b_drained", a_out.valid, 1'b0);
        chk("bp_fire_cnt", 32'(fire_cnt), 32'd3);

        // back-to-back, 12 beats with no idle cycle
        beats[0] = fill(32'h1);
        beats[1] = fill(32'h2);
        beats[2] = fill(32'h4);
        beats[3] = fill(32'h8);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < W; i++)
                beats[4+j][i] = 32'h1 << (4*i + j);
        beats[8]  = fill(32'h1234_5678);
        beats[9]  = fill(32'h1234_5678);
        beats[10] = fill(32'h0);
        beats[11] = fill(32'hFFFF_FFFF);
        exp3[0] = fill(32'hF);
        exp3[1] = {32'h0000_000F, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_F000,
                   32'h000F_0000, 32'h00F0_0000, 32'h0F00_0000, 32'hF000_0000};
        exp3[2] = fill(32'hFFFF_FFFF);
        for (int b = 0; b < 12; b++) begin
            a_in.valid   = 1'b1;
            a_in.packets = beats[b];
            #1;
            chk($sformatf("b2b_ready_%0d", b), a_in.ready, 1'b1);
            tick();
            if (b % 4 == 3) begin
                chk($sformatf("b2b_valid_%0d", b / 4), a_out.valid, 1'b1);
                chk($sformatf("b2b_packets_%0d", b / 4), a_out.packets, exp3[b / 4]);
            end
        end
        a_in.valid = 1'b0;
        chk("b2b_stripe_cnt", stripe_cnt, 16'd6);
        tick();
        chk("b2b_fire_cnt", 32'(fire_cnt), 32'd6);

        // clear mid-stripe discards the partial stripe and the beat offered with it
        push(fill(32'hAAAA_AAAA));
        push(fill(32'hAAAA_AAAA));
        chk("clr_pre_cnt", beat_cnt, 3'd2);
        clear        = 1'b1;
        a_in.valid   = 1'b1;
        a_in.packets = fill(32'hAAAA_AAAA);
        #1;
        chk("clr_in_ready", a_in.ready, 1'b0);
        tick();
        clear      = 1'b0;
        a_in.valid = 1'b0;
        chk("clr_beat_cnt", beat_cnt, 3'd0);
        push(fill(32'h1111_1111));
        push(fill(32'h1111_1111));
        push(fill(32'h1111_1111));
        chk("clr_three_cnt", beat_cnt, 3'd3);
        chk("clr_no_early", a_out.valid, 1'b0);
        push(fill(32'h1111_1111));
        chk("clr_out_valid", a_out.valid, 1'b1);
        chk("clr_packets", a_out.packets, fill(32'h0));
        chk("clr_stripe_cnt", stripe_cnt, 16'd7);
        tick();

        // K=1: every beat is echoed, stripe counter wraps
        errs = 0;
        for (int i = 0; i < 65537; i++) begin
            b_in.valid   = 1'b1;
            b_in.packets = fill(32'(i));
            tick();
            if (!b_out.valid || b_out.packets !== fill(32'(i))) errs++;
        end
        b_in.valid = 1'b0;
        chk("k1_echo_errs", 32'(errs), 32'd0);
        chk("k1_stripe_wrap", stripe_cnt1, 16'd1);
        chk("k1_beat_cnt", beat_cnt1, 1'b0);

        // async reset while both outputs hold a stripe
        b_out.ready = 1'b0;
        a_out.ready = 1'b0;
        b_in.valid   = 1'b1;
        b_in.packets = fill(32'hCAFE_F00D);
        tick();
        b_in.valid = 1'b0;
        push(fill(32'h5));
        push(fill(32'h5));
        push(fill(32'h5));
        push(fill(32'h5));
        chk("ar_pre_a_valid", a_out.valid, 1'b1);
        chk("ar_pre_b_valid", b_out.valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_a_valid", a_out.valid, 1'b0);
        chk("ar_b_valid", b_out.valid, 1'b0);
        chk("ar_a_packets", a_out.packets, '0);
        chk("ar_stripe_cnt", stripe_cnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parity_accumulator.md
Name: parity_accumulator

Overview:
- Downstream neighbour of bm_mult_unit in the EC engine.
- Consumes one W-packet multiply product per beat, one per data device. XOR-accumulates K consecutive products into one coding (parity) stripe of W packets.
- Presents the completed stripe on a valid/ready output toward the write-back stage.
- Double-buffered (accumulator + output register), so accumulation of stripe n+1 overlaps drain of stripe n.

Parameters:
- W, 8, bitmatrix word size; number of packets per product/stripe.
- PACKET_LENGTH, 32, bits per packet.
- K, 4, data devices (products) XORed per parity stripe; legal range K >= 1.
- CNT_W, $clog2(K)+1, width of the beat counter (derived; do not override).
- STRIPE_CNT_W, 16, width of the completed-stripe counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of the stripe being accumulated.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_packets  in  [PACKET_LENGTH-1:0] x [0:W-1]  product from bm_mult_unit (mult_product).
- out_valid  out  1  parity stripe valid.
- out_ready  in  1  consumer accepts the stripe.
- out_packets  out  [PACKET_LENGTH-1:0] x [0:W-1]  parity stripe.
- beat_cnt  out  CNT_W  beats accumulated in the current stripe (0..K-1).
- stripe_cnt  out  STRIPE_CNT_W  stripes handed off; wraps modulo 2^STRIPE_CNT_W.

Behaviour:
- Reset (async assert, sync release): acc = 0, beat_cnt = 0, out_valid = 0, out_packets = 0, stripe_cnt = 0. Reset mid-stripe discards all partial and pending data.
- Accept: in_fire = in_valid & in_ready. Output handoff: out_fire = out_valid & out_ready.
- Accumulator state ACCUM (beat_cnt = 0..K-1). On in_fire:
  - beat_cnt==0: acc <= in_packets (no XOR with stale data).
  - otherwise: acc <= acc ^ in_packets, packet-wise bitwise XOR; no width growth.
- Completion: in_fire with beat_cnt==K-1:
  - out_packets <= acc ^ in_packets (for K=1: in_packets).
  - out_valid <= 1; beat_cnt <= 0; stripe_cnt += 1.
  - Latency: the parity stripe is visible the cycle after the last beat.
- Otherwise, in_fire: beat_cnt += 1.
- in_ready = (beat_cnt != K-1) | ~out_valid | out_ready. Combinational from out_ready. Only the completing beat stalls, and only while the output register is occupied.
- Output:
  - out_valid stays high and out_packets is held stable until out_fire.
  - out_fire without a simultaneous completion: out_valid <= 0.
  - Simultaneous out_fire and completion: out_packets is replaced with the new stripe and out_valid stays 1 (back-to-back, no bubble).
- clear:
  - beat_cnt <= 0 and acc content is ignored. in_ready = 0 during clear; any in_valid that cycle is dropped.
  - The output register and stripe_cnt are unaffected.
  - clear has priority over in_fire.
- in_valid may be held across stalls. in_packets must be stable while in_valid & ~in_ready. No protocol assertions are required inside the block.
- Throughput: 1 beat/cycle sustained when out_ready=1; K beats per stripe.

Decomposition:
- Shared package ec_pkg holds:
  - W and PACKET_LENGTH defaults, matching global_parameters.v.
  - typedef packet_t = logic [PACKET_LENGTH-1:0].
  - typedef stripe_t = packet_t [0:W-1].
- No sub-module is needed; the 2-input XOR and the counter are inline.
- An optional elaboration-time check enforces K >= 1.

Test Plan:
- Reset/idle: rst_n=0 with in_valid=1 -> all outputs 0 and in_ready=1 after release; no stripe emitted.
- Basic stripe (W=8, PL=32, K=4): beats of all-packet values 0x0000_0001, 0x0000_0002, 0x0000_0004, 0x0000_0008, out_ready=1 -> out_valid one cycle after beat 4; every packet = 0x0000_000F; stripe_cnt=1.
- Backpressure: out_ready=0; two full stripes A=0xFF.. and B=0x0F.. are sent -> B's 4th beat stalls (in_ready=0) until A is taken; then B emitted; no loss or duplication.
- Back-to-back: continuous in_valid with out_ready=1, 12 beats -> 3 stripes, out_valid never drops between them, stripe_cnt=3, no in_ready bubble.
- clear mid-stripe: 2 beats of 0xAAAA_AAAA, clear, then 4 beats of 0x1111_1111 -> parity 0x0000_0000 (even count). The first 2 beats have no effect; beat_cnt=0 after clear.
- K=1 and wrap: K=1, 65537 beats -> every beat is echoed as a stripe; stripe_cnt wraps to 1. Async reset mid-output drops out_valid immediately.
